mux_arb_n: RTL

MUX_ARB_N -- requirements
Module: mux_arb_n

---
 rtl/mux_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/mux_arb_n.sv | 113 +++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared encodings for the arbitrating N-channel mux: mode codes, output FSM states
// and the channel-index width helper.
package mux_pkg;

    typedef enum logic [1:0] {
        MODE_SELECT      = 2'b00,
        MODE_PRIORITY    = 2'b01,
        MODE_ROUND_ROBIN = 2'b10,
        MODE_HOLD        = 2'b11
    } mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Channel-index width for nch channels, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned nch);
        return (nch > 2) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot request arbiter. With rr_en set the search starts at ptr and wraps;
// with rr_en clear it is a fixed lowest-index-first priority arbiter.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned  NCH  = 4,
    localparam int unsigned SELW = sel_width(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    input  logic            rr_en,
    output logic [NCH-1:0]  grant
);

    logic [NCH-1:0]  w_grant;
    logic            w_found;
    int unsigned     w_start;
    int unsigned     w_sum;
    logic [SELW-1:0] w_idx;

    // Scan every channel once from the start point, granting the first requester.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_sum   = 0;
        w_idx   = '0;
        w_start = rr_en ? 32'(ptr) : 32'd0;
        for (int unsigned k = 0; k < NCH; k++) begin
            w_sum = w_start + k;
            if (w_sum >= NCH) begin
                w_sum = w_sum - NCH;
            end
            w_idx = SELW'(w_sum);
            if (!w_found && req[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign grant = w_grant;

endmodule

// File: rtl/mux_arb_n.sv
// N-channel valid/ready mux with selectable arbitration feeding a single-entry
// output register. The register may be refilled on the same edge it drains.
module mux_arb_n
    import mux_pkg::*;
#(
    parameter int unsigned  WIDTH = 8,
    parameter int unsigned  NCH   = 4,
    localparam int unsigned SELW  = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_e           r_state;
    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_ch;
    logic [SELW-1:0]  r_rr_ptr;

    mode_e            w_mode;
    logic [NCH-1:0]   w_sel_grant;
    logic [NCH-1:0]   w_arb_grant;
    logic [NCH-1:0]   w_grant;
    logic [NCH-1:0]   w_xfer;
    logic             w_xfer_any;
    logic             w_load_en;
    logic [SELW-1:0]  w_xfer_idx;
    logic [WIDTH-1:0] w_xfer_data;

    assign w_mode = mode_e'(mode);

    // SELECT grant: direct index; indices beyond the last channel grant nothing.
    always_comb begin
        w_sel_grant = '0;
        if (32'(sel) < NCH) begin
            w_sel_grant[sel] = in_valid[sel];
        end
    end

    rr_arbiter #(
        .NCH (NCH)
    ) u_rr_arbiter (
        .req   (in_valid),
        .ptr   (r_rr_ptr),
        .rr_en (w_mode == MODE_ROUND_ROBIN),
        .grant (w_arb_grant)
    );

    // Pick the grant source for the current mode; HOLD grants nothing.
    always_comb begin
        w_grant = '0;
        unique case (w_mode)
            MODE_SELECT:      w_grant = w_sel_grant;
            MODE_PRIORITY:    w_grant = w_arb_grant;
            MODE_ROUND_ROBIN: w_grant = w_arb_grant;
            MODE_HOLD:        w_grant = '0;
        endcase
    end

    // Output register can take a word when empty or when it drains this cycle.
    assign w_load_en  = (r_state == ST_EMPTY) | out_ready;
    // rst_n gating keeps ready low during reset even though the state reads EMPTY.
    assign in_ready   = w_grant & {NCH{w_load_en & rst_n}};
    assign w_xfer     = in_valid & in_ready;
    assign w_xfer_any = |w_xfer;

    // Encode the one-hot transfer vector and mux out the winning channel's word.
    always_comb begin
        w_xfer_idx  = '0;
        w_xfer_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (w_xfer[i]) begin
                w_xfer_idx  = SELW'(i);
                w_xfer_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register FSM and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_data   <= '0;
            r_ch     <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_xfer_any) begin
                r_state <= ST_FULL;
                r_data  <= w_xfer_data;
                r_ch    <= w_xfer_idx;
                if (w_mode == MODE_ROUND_ROBIN) begin
                    r_rr_ptr <= (w_xfer_idx == SELW'(NCH - 1)) ? '0 : w_xfer_idx + SELW'(1);
                end
            end else if ((r_state == ST_FULL) && out_ready) begin
                // Drain without refill: data and channel keep their last value.
                r_state <= ST_EMPTY;
            end
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_ch    = r_ch;

endmodule
